// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry owner-tagged result register drained over valid/ready.
module alu_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [11:0] r0_op,
    input  logic [31:0] r0_src1,
    input  logic [31:0] r0_src2,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [11:0] r1_op,
    input  logic [31:0] r1_src1,
    input  logic [31:0] r1_src2,
    output logic [11:0] alu_op,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    output logic        o0_valid,
    input  logic        o0_ready,
    output logic        o1_valid,
    input  logic        o1_ready,
    output logic [31:0] o_result
);

    logic        full_q, full_d;
    logic        owner_q, owner_d;
    logic        ptr_q, ptr_d;
    logic [31:0] res_q, res_d;

    logic can_accept;
    logic gnt0, gnt1;
    logic owner_ready;

    assign owner_ready = owner_q ? o1_ready : o0_ready;
    assign can_accept  = ~full_q | owner_ready;

    // On a tie the requester named by ptr_q wins.
    assign gnt0 = r0_valid & (~r1_valid | ~ptr_q);
    assign gnt1 = r1_valid & (~r0_valid | ptr_q);

    assign r0_ready = gnt0 & can_accept;
    assign r1_ready = gnt1 & can_accept;

    // ALU shows the winner even while stalled, so the pending op stays visible.
    always_comb begin
        alu_op   = '0;
        alu_src1 = '0;
        alu_src2 = '0;
        if (gnt0) begin
            alu_op   = r0_op;
            alu_src1 = r0_src1;
            alu_src2 = r0_src2;
        end else if (gnt1) begin
            alu_op   = r1_op;
            alu_src1 = r1_src1;
            alu_src2 = r1_src2;
        end
    end

    always_comb begin
        full_d  = full_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        res_d   = res_q;
        if (r0_ready) begin
            full_d  = 1'b1;
            owner_d = 1'b0;
            ptr_d   = 1'b1;
            res_d   = alu_result;
        end else if (r1_ready) begin
            full_d  = 1'b1;
            owner_d = 1'b1;
            ptr_d   = 1'b0;
            res_d   = alu_result;
        end else if (full_q && owner_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q  <= 1'b0;
            owner_q <= 1'b0;
            ptr_q   <= PRIO_INIT;
            res_q   <= '0;
        end else begin
            full_q  <= full_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            res_q   <= res_d;
        end
    end

    assign o0_valid = full_q & ~owner_q;
    assign o1_valid = full_q & owner_q;
    assign o_result = res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration and the result register.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [11:0] r0_op = '0, r1_op = '0;
    logic [31:0] r0_src1 = '0, r0_src2 = '0, r1_src1 = '0, r1_src2 = '0;
    logic        o0_ready = 1'b1, o1_ready = 1'b1;

    logic        r0_ready_a, r1_ready_a, o0_valid_a, o1_valid_a;
    logic [11:0] alu_op_a;
    logic [31:0] alu_src1_a, alu_src2_a, alu_result_a, o_result_a;
    logic        r0_ready_b, r1_ready_b, o0_valid_b, o1_valid_b;
    logic [11:0] alu_op_b;
    logic [31:0] alu_src1_b, alu_src2_b, alu_result_b, o_result_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared ALU; multi-hot ops OR the selected results.
    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (op[0])  r |= a + b;
        if (op[1])  r |= a - b;
        if (op[2])  r |= {31'b0, $signed(a) < $signed(b)};
        if (op[3])  r |= {31'b0, a < b};
        if (op[4])  r |= a & b;
        if (op[5])  r |= ~(a | b);
        if (op[6])  r |= a | b;
        if (op[7])  r |= a ^ b;
        if (op[8])  r |= a << b[4:0];
        if (op[9])  r |= a >> b[4:0];
        if (op[10]) r |= 32'($signed(a) >>> b[4:0]);
        if (op[11]) r |= b;
        return r;
    endfunction

    assign alu_result_a = alu_ref(alu_op_a, alu_src1_a, alu_src2_a);
    assign alu_result_b = alu_ref(alu_op_b, alu_src1_b, alu_src2_b);

    alu_arbiter #(.PRIO_INIT(1'b0)) u_a (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(r0_ready_a), .r0_op(r0_op),
        .r0_src1(r0_src1), .r0_src2(r0_src2),
        .r1_valid(r1_valid), .r1_ready(r1_ready_a), .r1_op(r1_op),
        .r1_src1(r1_src1), .r1_src2(r1_src2),
        .alu_op(alu_op_a), .alu_src1(alu_src1_a), .alu_src2(alu_src2_a),
        .alu_result(alu_result_a),
        .o0_valid(o0_valid_a), .o0_ready(o0_ready),
        .o1_valid(o1_valid_a), .o1_ready(o1_ready),
        .o_result(o_result_a)
    );

    alu_arbiter #(.PRIO_INIT(1'b1)) u_b (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(r0_ready_b), .r0_op(r0_op),
        .r0_src1(r0_src1), .r0_src2(r0_src2),
        .r1_valid(r1_valid), .r1_ready(r1_ready_b), .r1_op(r1_op),
        .r1_src1(r1_src1), .r1_src2(r1_src2),
        .alu_op(alu_op_b), .alu_src1(alu_src1_b), .alu_src2(alu_src2_b),
        .alu_result(alu_result_b),
        .o0_valid(o0_valid_b), .o0_ready(o0_ready),
        .o1_valid(o1_valid_b), .o1_ready(o1_ready),
        .o_result(o_result_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_op = '0; r1_op = '0;
        r0_src1 = '0; r0_src2 = '0; r1_src1 = '0; r1_src2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        o0_ready = 1'b1; o1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Model state for the randomized phase (instance u_a, priority 0 at reset).
    logic        m_full, m_owner, m_ptr;
    logic [31:0] m_res;
    logic        e_g0, e_g1, e_can, e_rdy0, e_rdy1;
    logic [11:0] e_op;
    logic        w;
    logic [31:0] exp_res;

    initial begin
        // Reset state, asynchronous
        #1;
        check("rst_o0_valid", 32'(o0_valid_a), 32'd0);
        check("rst_o1_valid", 32'(o1_valid_a), 32'd0);
        check("rst_o_result", o_result_a, 32'd0);
        check("rst_r0_ready", 32'(r0_ready_a), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single requester add
        @(negedge clk);
        r0_valid = 1'b1; r0_op = 12'h001; r0_src1 = 32'd5; r0_src2 = 32'd7;
        #1;
        check("add_r0_ready", 32'(r0_ready_a), 32'd1);
        check("add_alu_op", 32'(alu_op_a), 32'h001);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        check("add_o0_valid", 32'(o0_valid_a), 32'd1);
        check("add_o_result", o_result_a, 32'd12);
        check("add_o1_valid", 32'(o1_valid_a), 32'd0);

        // Tie from reset: u_a grants r0 first, u_b (priority 1) grants r1 first
        do_reset();
        r0_valid = 1'b1; r0_op = 12'h002; r0_src1 = 32'd10; r0_src2 = 32'd3;
        r1_valid = 1'b1; r1_op = 12'h004; r1_src1 = 32'hFFFF_FFFF; r1_src2 = 32'd1;
        #1;
        check("tie_r0_ready", 32'(r0_ready_a), 32'd1);
        check("tie_r1_ready", 32'(r1_ready_a), 32'd0);
        check("prio1_r1_ready", 32'(r1_ready_b), 32'd1);
        check("prio1_r0_ready", 32'(r0_ready_b), 32'd0);
        check("prio1_alu_op", 32'(alu_op_b), 32'h004);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        check("tie_o0_valid", 32'(o0_valid_a), 32'd1);
        check("tie_o0_result", o_result_a, 32'd7);
        check("tie_r1_ready2", 32'(r1_ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
        r1_valid = 1'b0;
        #1;
        check("tie_o1_valid", 32'(o1_valid_a), 32'd1);
        check("tie_o1_result", o_result_a, 32'd1);
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        check("tie_ptr_back_r0", 32'(r0_ready_a), 32'd1);
        r0_valid = 1'b0; r1_valid = 1'b0;

        // Backpressure on owner 1
        @(negedge clk);
        r1_valid = 1'b1; r1_op = 12'h400; r1_src1 = 32'h8000_0000; r1_src2 = 32'd4;
        o1_ready = 1'b0;
        #1;
        check("bp_r1_ready", 32'(r1_ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
        r1_valid = 1'b0;
        r0_valid = 1'b1; r0_op = 12'h001; r0_src1 = 32'd1; r0_src2 = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_r0_ready", 32'(r0_ready_a), 32'd0);
            check("bp_o1_valid", 32'(o1_valid_a), 32'd1);
            check("bp_o_result", o_result_a, 32'hF800_0000);
            check("bp_alu_op", 32'(alu_op_a), 32'h001);
            @(posedge clk);
            @(negedge clk);
        end
        o1_ready = 1'b1;
        #1;
        check("bp_release_r0_ready", 32'(r0_ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        check("bp_o0_valid", 32'(o0_valid_a), 32'd1);
        check("bp_o1_valid_after", 32'(o1_valid_a), 32'd0);
        check("bp_o0_result", o_result_a, 32'd3);

        // Continuous contention: r0 won last, so r1 leads
        r0_valid = 1'b1; r0_op = 12'h080; r0_src1 = $urandom; r0_src2 = $urandom;
        r1_valid = 1'b1; r1_op = 12'h040; r1_src1 = $urandom; r1_src2 = $urandom;
        w = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("cont_r0_ready", 32'(r0_ready_a), 32'(!w));
            check("cont_r1_ready", 32'(r1_ready_a), 32'(w));
            exp_res = w ? alu_ref(r1_op, r1_src1, r1_src2) : alu_ref(r0_op, r0_src1, r0_src2);
            @(posedge clk);
            @(negedge clk);
            check("cont_o0_valid", 32'(o0_valid_a), 32'(!w));
            check("cont_o1_valid", 32'(o1_valid_a), 32'(w));
            check("cont_o_result", o_result_a, exp_res);
            if (w) begin r1_src1 = $urandom; r1_src2 = $urandom; end
            else   begin r0_src1 = $urandom; r0_src2 = $urandom; end
            w = ~w;
        end

        // Reset while a result is held and stalled
        r1_valid = 1'b0;
        r0_op = 12'h001; r0_src1 = 32'd1; r0_src2 = 32'd1;
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0; o0_ready = 1'b0;
        #1;
        check("mid_o0_valid", 32'(o0_valid_a), 32'd1);
        check("mid_o_result", o_result_a, 32'd2);
        resetn = 1'b0;
        #1;
        check("mid_rst_o0_valid", 32'(o0_valid_a), 32'd0);
        check("mid_rst_o_result", o_result_a, 32'd0);
        @(negedge clk);
        resetn = 1'b1; o0_ready = 1'b1;
        r0_valid = 1'b1; r0_op = 12'h800; r0_src1 = 32'd0; r0_src2 = 32'h1234_5000;
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        check("lui_o0_valid", 32'(o0_valid_a), 32'd1);
        check("lui_o_result", o_result_a, 32'h1234_5000);

        // Randomized traffic against the model
        do_reset();
        m_full = 1'b0; m_owner = 1'b0; m_ptr = 1'b0; m_res = '0;
        for (int i = 0; i < 400; i++) begin
            check("rnd_o0_valid", 32'(o0_valid_a), 32'(m_full && !m_owner));
            check("rnd_o1_valid", 32'(o1_valid_a), 32'(m_full && m_owner));
            check("rnd_o_result", o_result_a, m_res);
            if (!r0_valid && $urandom_range(0, 3) != 0) begin
                r0_valid = 1'b1;
                r0_op = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'(1 << $urandom_range(0, 11));
                r0_src1 = $urandom; r0_src2 = $urandom;
            end
            if (!r1_valid && $urandom_range(0, 3) != 0) begin
                r1_valid = 1'b1;
                r1_op = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'(1 << $urandom_range(0, 11));
                r1_src1 = $urandom; r1_src2 = $urandom;
            end
            o0_ready = ($urandom_range(0, 2) != 0);
            o1_ready = ($urandom_range(0, 2) != 0);
            e_g0   = r0_valid && (!r1_valid || !m_ptr);
            e_g1   = r1_valid && (!r0_valid || m_ptr);
            e_can  = !m_full || (m_owner ? o1_ready : o0_ready);
            e_rdy0 = e_g0 && e_can;
            e_rdy1 = e_g1 && e_can;
            e_op   = e_g0 ? r0_op : (e_g1 ? r1_op : 12'h000);
            #1;
            check("rnd_r0_ready", 32'(r0_ready_a), 32'(e_rdy0));
            check("rnd_r1_ready", 32'(r1_ready_a), 32'(e_rdy1));
            check("rnd_alu_op", 32'(alu_op_a), 32'(e_op));
            @(posedge clk);
            if (e_rdy0) begin
                m_full = 1'b1; m_owner = 1'b0; m_ptr = 1'b1;
                m_res = alu_ref(r0_op, r0_src1, r0_src2);
            end else if (e_rdy1) begin
                m_full = 1'b1; m_owner = 1'b1; m_ptr = 1'b0;
                m_res = alu_ref(r1_op, r1_src1, r1_src2);
            end else if (m_full && (m_owner ? o1_ready : o0_ready)) begin
                m_full = 1'b0;
            end
            @(negedge clk);
            if (e_rdy0) r0_valid = 1'b0;
            if (e_rdy1) r1_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
